game_ctrl: RTL

Top-level game sequencer for the flappy-ghost game. Owns the three-state game FSM (idle / playing / over) whose one-hot `state` bus drives the collision/fail detector, the bird physics and the pillar scroller. Turns the raw player button into start, flap and restart events. Keeps the BCD score from pillar-pass pulses and the session best score.

---
 rtl/game_ctrl_if.sv | 23 ++
 rtl/game_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - player/detector/scorer signal bundle for the game sequencer
interface game_ctrl_if;
  logic        btn;
  logic        frame_tick;
  logic        isfail;
  logic        pass_p1;
  logic        pass_p2;
  logic [2:0]  state;
  logic        flap;
  logic        new_game;
  logic [15:0] score;
  logic [15:0] best;

  modport master (
    output btn, frame_tick, isfail, pass_p1, pass_p2,
    input  state, flap, new_game, score, best
  );

  modport slave (
    input  btn, frame_tick, isfail, pass_p1, pass_p2,
    output state, flap, new_game, score, best
  );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - flappy-ghost game FSM, button events, BCD score and best score
module game_ctrl #(
  parameter int unsigned OVER_HOLD_FRAMES = 60
) (
  input logic         clk,
  input logic         rst_n,
  game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    PLAYING = 3'b010,
    OVER    = 3'b100
  } state_t;

  state_t      st;
  logic        s1, s2, d;
  logic        btn_rise;
  logic        flap_r, new_game_r;
  logic [15:0] score_r, best_r, score_add;
  logic [7:0]  hold_cnt;

  // Saturating BCD increment; 9999 sticks.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign btn_rise = s2 & ~d;

  always_comb begin
    score_add = score_r;
    case ({bus.pass_p1, bus.pass_p2})
      2'b01, 2'b10: score_add = bcd_inc(score_r);
      2'b11:        score_add = bcd_inc(bcd_inc(score_r));
      default:      score_add = score_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
      d  <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      flap_r     <= 1'b0;
      new_game_r <= 1'b0;
      score_r    <= 16'h0000;
      best_r     <= 16'h0000;
      hold_cnt   <= 8'd0;
    end else begin
      flap_r     <= 1'b0;
      new_game_r <= 1'b0;
      case (st)
        IDLE: begin
          if (btn_rise) begin
            st         <= PLAYING;
            new_game_r <= 1'b1;
            score_r    <= 16'h0000;
          end
        end
        PLAYING: begin
          // A failing cycle swallows any flap and pass pulses arriving with it.
          if (bus.isfail) begin
            st       <= OVER;
            hold_cnt <= 8'(OVER_HOLD_FRAMES);
            if (score_r > best_r) best_r <= score_r;
          end else begin
            flap_r  <= btn_rise;
            score_r <= score_add;
          end
        end
        OVER: begin
          if (hold_cnt == 8'd0) begin
            if (btn_rise) st <= IDLE;
          end else if (bus.frame_tick) begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state    = st;
  assign bus.flap     = flap_r;
  assign bus.new_game = new_game_r;
  assign bus.score    = score_r;
  assign bus.best     = best_r;

endmodule
